cache_access_ctrl: RTL

Sequencing controller for the direct-mapped cache datapath (3-bit tag, 10-bit index, 2-bit word offset, 128-bit main-memory blocks).
- Accepts one 15-bit word address at a time from the address source.
- Runs the cache lookup and, on a miss, the block fetch from main memory and the line refill.
- Returns a response tagged hit/miss and keeps access, hit and miss statistics.
- Stops after a configured number of accesses.

---
 rtl/cache_access_ctrl_if.sv | 33 +++
 rtl/cache_access_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cache_access_ctrl_if.sv
// Handshake and bus signals between the cache access controller and its
// address source, cache datapath, main memory and response consumer.
interface cache_access_ctrl_if #(
  parameter int ADDR_W   = 15,
  parameter int OFFSET_W = 2
);
  logic                       req_valid;
  logic [ADDR_W-1:0]          req_addr;
  logic                       req_ready;
  logic [ADDR_W-1:0]          cache_addr;
  logic                       lookup_hit;
  logic                       cache_fill;
  logic                       mem_rd_req;
  logic [ADDR_W-OFFSET_W-1:0] mem_addr;
  logic                       mem_rd_ack;
  logic                       resp_valid;
  logic                       resp_hit;
  logic                       resp_ready;

  // Controller side.
  modport master (
    input  req_valid, req_addr, lookup_hit, mem_rd_ack, resp_ready,
    output req_ready, cache_addr, cache_fill, mem_rd_req, mem_addr,
           resp_valid, resp_hit
  );

  // Environment side: address source, cache, memory and consumer.
  modport slave (
    output req_valid, req_addr, lookup_hit, mem_rd_ack, resp_ready,
    input  req_ready, cache_addr, cache_fill, mem_rd_req, mem_addr,
           resp_valid, resp_hit
  );
endinterface

// File: rtl/cache_access_ctrl.sv
// Sequencing controller for a direct-mapped cache: lookup, miss fetch, refill,
// tagged response, and saturating access/hit/miss statistics.
module cache_access_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int OFFSET_W     = 2,
  parameter int NUM_ACCESSES = 8192,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_access_ctrl_if.master bus,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESPOND,
    DONE
  } state_t;

  // Access count value whose handshake completes the run.
  localparam logic [CNT_W-1:0] LAST_ACCESS = CNT_W'(NUM_ACCESSES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                resp_hit_q;
  logic [CNT_W-1:0]    access_q, hit_q, miss_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: reset is synchronous, so it only takes effect on a clock edge; every
  // register (no memories here) is cleared so the block restarts from a clean
  // state even when reset arrives mid-miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      resp_hit_q <= 1'b0;
      access_q   <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      state_q <= state_d;

      if (state_q == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
      end

      if (state_q == LOOKUP) begin
        resp_hit_q <= bus.lookup_hit;
        if (bus.lookup_hit) hit_q  <= sat_inc(hit_q);
        else                miss_q <= sat_inc(miss_q);
      end

      if (state_q == RESPOND && bus.resp_ready) begin
        access_q <= sat_inc(access_q);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.mem_rd_req = 1'b0;
    bus.cache_fill = 1'b0;
    bus.resp_valid = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = bus.lookup_hit ? RESPOND : MISS_REQ;
      end
      MISS_REQ: begin
        bus.mem_rd_req = 1'b1;
        if (bus.mem_rd_ack) state_d = REFILL;
      end
      REFILL: begin
        // Refill is a single strobe; the line's new tag match is not counted.
        bus.cache_fill = 1'b1;
        state_d        = RESPOND;
      end
      RESPOND: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = (access_q == LAST_ACCESS) ? DONE : IDLE;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cache_addr = addr_q;
  assign bus.mem_addr   = addr_q[ADDR_W-1:OFFSET_W];
  assign bus.resp_hit   = resp_hit_q;
  assign access_count   = access_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule
